iot_event_scheduler: RTL

- Collects connect/disconnect requests from N_DEV IoT device agents and serialises them into the single change/on_off event interface of the active-device counter (monitor).
- Issues at most one event per clock, with round-robin fairness between devices.
- Keeps a per-device active bitmap so that redundant events (on-while-on, off-while-off) never reach the counter.
- Sits between the device agents and the monitor; its change/on_off outputs drive the monitor's change/on_off inputs directly.

---
 rtl/iot_event_scheduler_pkg.sv | 11 +
 rtl/iot_event_scheduler_if.sv | 42 ++++
 rtl/iot_event_scheduler_rr_arbiter.sv | 57 +++++
 rtl/iot_event_scheduler.sv | 80 ++++++++
 4 files changed

// File: rtl/iot_event_scheduler_pkg.sv
// Shared definitions for the IoT event scheduler and the active-device monitor.
//   N_DEV_DEFAULT : default number of device requesters
//   EV_UP/EV_DOWN : on_off encodings seen by the monitor (count up / count down)
package iot_pkg;

    localparam int unsigned N_DEV_DEFAULT = 4;

    localparam logic EV_UP   = 1'b1;
    localparam logic EV_DOWN = 1'b0;

endpackage : iot_pkg

// File: rtl/iot_event_scheduler_if.sv
// Device-side bundle of the IoT event scheduler.
//   req        : per-device request, held until acked
//   req_on     : per-device direction (1 = turning on), valid while req is high
//   ack        : one-hot, one-cycle grant pulse
//   change     : event to the monitor this cycle
//   on_off     : monitor count direction, meaningful only with change
//   active_map : current on/off state of each device
//   dropped    : granted request was redundant, no event issued
// master = device agents side, slave = scheduler side.
interface iot_event_scheduler_if #(
    parameter int unsigned N = 4
) ();

    logic [N-1:0] req;
    logic [N-1:0] req_on;
    logic [N-1:0] ack;
    logic         change;
    logic         on_off;
    logic [N-1:0] active_map;
    logic         dropped;

    modport master (
        output req,
        output req_on,
        input  ack,
        input  change,
        input  on_off,
        input  active_map,
        input  dropped
    );

    modport slave (
        input  req,
        input  req_on,
        output ack,
        output change,
        output on_off,
        output active_map,
        output dropped
    );

endinterface : iot_event_scheduler_if

// File: rtl/iot_event_scheduler_rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
//   clk, rst    : clock and synchronous active-high reset (pointer -> 0)
//   eligible    : per-requester eligibility this cycle
//   grant       : one-hot winner (combinational)
//   grant_valid : some requester won
// The pointer moves to (winner + 1) mod N on every grant.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] eligible,
    output logic [N-1:0] grant,
    output logic         grant_valid
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]  ptr;
    logic [PW-1:0]  win;
    logic [N-1:0]   hi_mask;
    logic [2*N-1:0] scan;
    logic           found;

    // Lower half keeps only requesters at or above the pointer; the upper
    // half is the unmasked copy, so the first set bit of the concatenation
    // is the first eligible requester in wrapped order.
    always_comb begin
        hi_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            hi_mask[i] = (i >= 32'(ptr));
        end
        scan  = {eligible, eligible & hi_mask};
        found = 1'b0;
        win   = '0;
        for (int unsigned j = 0; j < 2 * N; j++) begin
            if (scan[j] && !found) begin
                found = 1'b1;
                win   = PW'(j % N);
            end
        end
        grant = '0;
        if (found) begin
            grant[win] = 1'b1;
        end
        grant_valid = found;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_valid) begin
            ptr <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
        end
    end

endmodule : rr_arbiter

// File: rtl/iot_event_scheduler.sv
// Serialises device connect/disconnect requests into the monitor's single
// change/on_off event interface, one grant per clock, round-robin fair.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset, shared with the monitor
//   bus : iot_event_scheduler_if.slave (req/req_on in; ack, change, on_off,
//         active_map, dropped out, all registered)
// Redundant requests (on-while-on, off-while-off) are acked but flagged via
// dropped instead of reaching the monitor.
module iot_event_scheduler
    import iot_pkg::*;
#(
    parameter int unsigned N_DEV = N_DEV_DEFAULT
) (
    input logic                  clk,
    input logic                  rst,
    iot_event_scheduler_if.slave bus
);

    logic [N_DEV-1:0] ack_q;
    logic             change_q;
    logic             on_off_q;
    logic [N_DEV-1:0] map_q;
    logic             dropped_q;

    logic [N_DEV-1:0] eligible;
    logic [N_DEV-1:0] grant;
    logic             grant_valid;
    logic             win_on;
    logic             win_active;

    // A device acked last cycle may still show its old req; mask it out.
    assign eligible = bus.req & ~ack_q;

    rr_arbiter #(
        .N (N_DEV)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .eligible    (eligible),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // Selecting through the one-hot grant keeps X on idle req_on bits out.
    always_comb begin
        win_on     = |(grant & bus.req_on);
        win_active = |(grant & map_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q     <= '0;
            change_q  <= 1'b0;
            on_off_q  <= EV_DOWN;
            map_q     <= '0;
            dropped_q <= 1'b0;
        end else begin
            ack_q     <= grant;
            change_q  <= 1'b0;
            on_off_q  <= EV_DOWN;
            dropped_q <= 1'b0;
            if (grant_valid) begin
                if (win_on != win_active) begin
                    change_q <= 1'b1;
                    on_off_q <= win_on ? EV_UP : EV_DOWN;
                    map_q    <= map_q ^ grant;
                end else begin
                    dropped_q <= 1'b1;
                end
            end
        end
    end

    assign bus.ack        = ack_q;
    assign bus.change     = change_q;
    assign bus.on_off     = on_off_q;
    assign bus.active_map = map_q;
    assign bus.dropped    = dropped_q;

endmodule : iot_event_scheduler
